// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone B4 router with mask/base decode,
// decode-error responder, watchdog timeout and sticky error capture.
module wb_interconnect #(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'h0000FFFF, 32'h00000000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    {32'hFFFFFFFF, 32'hFFFFF000},
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic                       WE,
  input  logic [ADDR_W-1:0]          ADR,
  input  logic [DATA_W-1:0]          DAT_O,
  input  logic [2:0]                 CTI_O,
  output logic [DATA_W-1:0]          DAT_I,
  output logic                       ACK,
  output logic                       ERR,
  output logic                       RTY,
  output logic [N_SLAVES-1:0]        s_CYC,
  output logic [N_SLAVES-1:0]        s_STB,
  output logic [ADDR_W-1:0]          s_ADR,
  output logic [DATA_W-1:0]          s_DAT_O,
  output logic                       s_WE,
  output logic [2:0]                 s_CTI,
  input  logic [N_SLAVES*DATA_W-1:0] s_DAT_I,
  input  logic [N_SLAVES-1:0]        s_ACK,
  input  logic [N_SLAVES-1:0]        s_ERR,
  input  logic [N_SLAVES-1:0]        s_RTY,
  input  logic                       clr_err,
  output logic                       bus_err,
  output logic                       bus_err_to,
  output logic [ADDR_W-1:0]          bus_err_adr
);

  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state;
  logic [SW-1:0]       sel_q;
  logic                hit_q;
  logic                abort_q;
  logic [TW-1:0]       tcnt;
  logic                err_q;
  logic                err_to_q;
  logic [ADDR_W-1:0]   err_adr_q;

  logic [SW-1:0]       dec_sel;
  logic                dec_hit;
  logic [SW-1:0]       cur_sel;
  logic                route;
  logic                resp;
  logic                stb_act;
  logic                expire;

  // Descending scan so the lowest matching window wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((ADR & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[i*ADDR_W +: ADDR_W] &
           SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  assign cur_sel = (state == ACTIVE) ? sel_q : dec_sel;
  assign route   = ((state == ACTIVE) ? hit_q : dec_hit) & ~abort_q;
  assign stb_act = CYC & STB;
  assign resp    = route &
                   (s_ACK[cur_sel] | s_ERR[cur_sel] | s_RTY[cur_sel]);
  assign expire  = (TIMEOUT > 0) && route && stb_act && !resp &&
                   (tcnt == TW'(TIMEOUT - 1));

  assign s_ADR   = ADR;
  assign s_DAT_O = DAT_O;
  assign s_WE    = WE;
  assign s_CTI   = CTI_O;

  always_comb begin
    s_CYC = '0;
    s_STB = '0;
    DAT_I = '0;
    ACK   = 1'b0;
    RTY   = 1'b0;
    ERR   = 1'b0;
    if (!rst) begin
      if (route) begin
        s_CYC[cur_sel] = CYC;
        s_STB[cur_sel] = STB;
        DAT_I = s_DAT_I[cur_sel*DATA_W +: DATA_W];
        ACK   = s_ACK[cur_sel];
        RTY   = s_RTY[cur_sel];
        ERR   = s_ERR[cur_sel] | err_q;
      end else begin
        ERR   = err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel_q       <= '0;
      hit_q       <= 1'b0;
      abort_q     <= 1'b0;
      tcnt        <= '0;
      err_q       <= 1'b0;
      err_to_q    <= 1'b0;
      err_adr_q   <= '0;
      bus_err     <= 1'b0;
      bus_err_to  <= 1'b0;
      bus_err_adr <= '0;
    end else begin
      case (state)
        IDLE: if (CYC) begin
          state <= ACTIVE;
          sel_q <= dec_sel;
          hit_q <= dec_hit;
        end
        ACTIVE: if (!CYC) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!CYC)
        abort_q <= 1'b0;
      else if (expire)
        abort_q <= 1'b1;

      if (!route || !CYC || resp || expire)
        tcnt <= '0;
      else if (TIMEOUT > 0 && STB && tcnt != TW'(TIMEOUT))
        tcnt <= tcnt + 1'b1;

      // An aborted slave answers like a decode miss until CYC drops.
      if (!route) begin
        err_q    <= stb_act & ~err_q;
        err_to_q <= abort_q;
      end else begin
        err_q    <= expire;
        err_to_q <= expire;
      end
      err_adr_q <= ADR;

      if (err_q && (!bus_err || clr_err)) begin
        bus_err     <= 1'b1;
        bus_err_to  <= err_to_q;
        bus_err_adr <= err_adr_q;
      end else if (clr_err) begin
        bus_err     <= 1'b0;
        bus_err_to  <= 1'b0;
        bus_err_adr <= '0;
      end
    end
  end

endmodule
